mazesolver_soc_key_in: RTL

MAZESOLVER_SOC_KEY_IN -- requirements
Module: mazesolver_soc_key_in

---
 rtl/mazesolver_pio_pkg.sv | 15 +
 rtl/mazesolver_debounce.sv | 35 +++
 rtl/mazesolver_soc_key_in.sv | 106 ++++++++++
 3 files changed

// File: rtl/mazesolver_pio_pkg.sv
// Shared register map and capture-edge selection for the maze-solver key/switch PIO.
// Imported by mazesolver_soc_key_in and its testbench.
package mazesolver_pio_pkg;

    typedef enum logic [1:0] {
        EDGE_RISING  = 2'd0,
        EDGE_FALLING = 2'd1,
        EDGE_ANY     = 2'd2
    } edge_type_e;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

endpackage

// File: rtl/mazesolver_debounce.sv
// Single-bit debounce filter: the stable value follows i_sync only after it has
// differed for DEBOUNCE_CYCLES consecutive clocks. Used when MAZESOLVER_KEY_DEBOUNCE_EN is set.
module mazesolver_debounce #(
    parameter logic        RESET_VAL       = 1'b0,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_sync,
    output logic o_stable
);

    localparam logic [15:0] CNT_MAX = DEBOUNCE_CYCLES - 16'd1;

    logic [15:0] r_cnt;
    logic        r_stable;

    // Any return to the stable level restarts the count, so glitches never accumulate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= 16'd0;
            r_stable <= RESET_VAL;
        end else if (i_sync == r_stable) begin
            r_cnt <= 16'd0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt    <= 16'd0;
            r_stable <= i_sync;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/mazesolver_soc_key_in.sv
// Avalon-MM key/switch input port with edge capture and level interrupt.
// Optional per-bit debounce filter is compiled in with MAZESOLVER_KEY_DEBOUNCE_EN.
module mazesolver_soc_key_in
    import mazesolver_pio_pkg::*;
#(
    parameter int          WIDTH           = 4,
    parameter edge_type_e  EDGE_TYPE       = EDGE_FALLING,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // Released active-low keys idle high; presetting to 1s avoids a spurious edge after reset.
    localparam logic [WIDTH-1:0] RST_VAL =
        (EDGE_TYPE == EDGE_FALLING) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_prev_in;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] w_data_in;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic             w_unused_ok;

    assign w_unused_ok = &{1'b0, writedata, DEBOUNCE_CYCLES};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= RST_VAL;
            r_sync2 <= RST_VAL;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

`ifdef MAZESOLVER_KEY_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        mazesolver_debounce #(
            .RESET_VAL       (RST_VAL[i]),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_sync   (r_sync2[i]),
            .o_stable (w_data_in[i])
        );
    end
`else
    assign w_data_in = r_sync2;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_prev_in <= RST_VAL;
        else          r_prev_in <= w_data_in;
    end

    always_comb begin
        w_edge = '0;
        case (EDGE_TYPE)
            EDGE_RISING:  w_edge = ~r_prev_in & w_data_in;
            EDGE_FALLING: w_edge = r_prev_in & ~w_data_in;
            default:      w_edge = r_prev_in ^ w_data_in;
        endcase
    end

    // Avalon-MM slave: a write is chipselect && !write_n, taking effect at the next clk edge;
    // reads have zero wait states and decode address alone.
    assign w_wr  = chipselect & ~write_n;
    assign w_clr = (w_wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irqmask <= '0;
            r_edgecap <= '0;
        end else begin
            if (w_wr && address == ADDR_IRQMASK) r_irqmask <= writedata[WIDTH-1:0];
            // New edges are ORed in after the clear so a coincident edge wins.
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = w_data_in;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = r_irqmask;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = r_edgecap;
            default:      readdata = '0;
        endcase
    end

    assign irq = |(r_edgecap & r_irqmask);

endmodule
